// File: rtl/oam_dma_pkg.sv
// oam_dma_pkg: shared types and constants for the sprite-DMA controller.
//   dma_state_t   controller state encoding
//   OAM_DMA_ADDR  CPU write address that triggers a sprite DMA ($4014)
//   OAMDATA_ADDR  destination address of every DMA write ($2004)
package oam_dma_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_t;

    localparam logic [15:0] OAM_DMA_ADDR = 16'h4014;
    localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

endpackage

// File: rtl/oam_dma.sv
// oam_dma: sprite-DMA controller and bus arbiter between the 6502 core and
// the system bus. A core write of P to DMA_REG halts the core and copies
// $P00-$PFF to OAM_DATA, one read/write pair per byte. When idle the core's
// bus signals pass straight through.
// Ports:
//   clk         system clock, state advances on the falling edge (as the cpu)
//   rst_n       asynchronous active-low reset
//   cpu_addr    core address          cpu_rw     core direction (1 = read)
//   cpu_wdata   core write data       cpu_rdy    1 = core may advance
//   bus_addr    arbitrated address    bus_rw     arbitrated direction
//   bus_wdata   arbitrated write data bus_rdata  read data from the decoder
//   dma_active  1 while the controller owns the bus
//   dma_index   current byte index (debug)
module oam_dma
    import oam_dma_pkg::*;
#(
    parameter logic [15:0] DMA_REG  = OAM_DMA_ADDR,
    parameter logic [15:0] OAM_DATA = OAMDATA_ADDR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_rdy,
    output logic [15:0] bus_addr,
    output logic        bus_rw,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    output logic        dma_active,
    output logic [7:0]  dma_index
);

    dma_state_t state;
    dma_state_t state_nxt;
    logic [7:0] page;
    logic [7:0] index;
    logic [7:0] latch;
    logic       parity;
    logic       trigger;

    // Only an idle controller listens for the trigger; writes to DMA_REG
    // issued while halted are ignored.
    assign trigger   = (state == IDLE) && !cpu_rw && (cpu_addr == DMA_REG);
    assign dma_index = index;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            page   <= 8'h00;
            index  <= 8'h00;
            latch  <= 8'h00;
            parity <= 1'b0;
        end else begin
            // Free-running cycle parity, used to align the first read.
            parity <= ~parity;
            state  <= state_nxt;
            if (trigger) begin
                page  <= cpu_wdata;
                index <= 8'h00;
            end
            if (state == READ) begin
                latch <= bus_rdata;
            end
            // The last byte leaves index at $FF so it never rolls into the
            // next page.
            if ((state == WRITE) && (index != 8'hFF)) begin
                index <= index + 8'd1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        cpu_rdy    = 1'b0;
        dma_active = 1'b1;
        bus_addr   = cpu_addr;
        bus_rw     = cpu_rw;
        bus_wdata  = cpu_wdata;
        case (state)
            IDLE: begin
                cpu_rdy    = 1'b1;
                dma_active = 1'b0;
                if (trigger) begin
                    state_nxt = HALT;
                end
            end
            HALT: begin
                // Dummy read at whatever address the halted core presents.
                bus_rw    = 1'b1;
                state_nxt = parity ? ALIGN : READ;
            end
            ALIGN: begin
                bus_rw    = 1'b1;
                state_nxt = READ;
            end
            READ: begin
                bus_addr  = {page, index};
                bus_rw    = 1'b1;
                state_nxt = WRITE;
            end
            WRITE: begin
                bus_addr  = OAM_DATA;
                bus_rw    = 1'b0;
                bus_wdata = latch;
                state_nxt = (index == 8'hFF) ? IDLE : READ;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
module tb_oam_dma;

    logic        clk;
    logic        rst_n;
    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic [7:0]  cpu_wdata;
    logic        cpu_rdy;
    logic [15:0] bus_addr;
    logic        bus_rw;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        dma_active;
    logic [7:0]  dma_index;

    logic [7:0]  mem [0:65535];

    typedef struct {
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  data;
        logic [7:0]  idx;
        bit          dummy;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   edge_cnt;

    oam_dma dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_addr   (cpu_addr),
        .cpu_rw     (cpu_rw),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdy    (cpu_rdy),
        .bus_addr   (bus_addr),
        .bus_rw     (bus_rw),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .dma_active (dma_active),
        .dma_index  (dma_index)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    assign bus_rdata = mem[bus_addr];

    // Falling edges seen since reset release; the parity flop equals its LSB.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the rising edge, opposite to the DUT's active edge.
    always @(posedge clk) begin
        if (dma_active) begin
            exp_t e;
            chk("rdy_low_in_dma", 32'(cpu_rdy), 32'd0);
            if (q.size() == 0) begin
                chk("unexpected_dma_cycle", {16'd0, bus_addr}, 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                chk("dma_addr", 32'(bus_addr), e.dummy ? 32'(cpu_addr) : 32'(e.addr));
                chk("dma_rw", 32'(bus_rw), 32'(e.rw));
                if (!e.dummy) chk("dma_index", 32'(dma_index), 32'(e.idx));
                if (!e.rw) chk("dma_wdata", 32'(bus_wdata), 32'(e.data));
            end
        end else begin
            chk("idle_mirror", {6'd0, cpu_rdy, bus_rw, bus_wdata, bus_addr},
                {6'd0, 1'b1, cpu_rw, cpu_wdata, cpu_addr});
        end
    end

    task automatic drive(input logic [15:0] a, input logic rw, input logic [7:0] d);
        cpu_addr  = a;
        cpu_rw    = rw;
        cpu_wdata = d;
    endtask

    task automatic drive_junk();
        logic [15:0] a;
        a = ($urandom_range(0, 3) == 0) ? 16'h4014 : 16'($urandom);
        drive(a, 1'($urandom), 8'($urandom));
    endtask

    // Random core traffic that never writes the trigger register.
    task automatic idle_ops(input int n);
        for (int i = 0; i < n; i++) begin
            logic [15:0] a;
            logic        rw;
            @(negedge clk); #1;
            a  = 16'($urandom);
            rw = 1'($urandom);
            if (a == 16'h4014) rw = 1'b1;
            drive(a, rw, 8'($urandom));
        end
    endtask

    // Issue a trigger for page pg on an edge chosen so that the cycle after
    // the trigger has the requested parity, and queue the expected bus cycles.
    task automatic start_dma(input logic [7:0] pg, input bit want_align, output int align);
        exp_t e;
        @(negedge clk); #1;
        drive(16'h0000, 1'b1, 8'h00);
        // After the trigger edge the parity flop holds (edge_cnt + 1) mod 2.
        if ((((edge_cnt + 1) % 2) == 1) != want_align) begin
            @(negedge clk); #1;
        end
        align = ((edge_cnt + 1) % 2);
        e = '{addr: 16'h0, rw: 1'b1, data: 8'h0, idx: 8'h0, dummy: 1'b1};
        q.push_back(e);
        if (align == 1) q.push_back(e);
        for (int i = 0; i < 256; i++) begin
            q.push_back('{addr: {pg, 8'(i)}, rw: 1'b1, data: 8'h0, idx: 8'(i), dummy: 1'b0});
            q.push_back('{addr: 16'h2004, rw: 1'b0, data: mem[{pg, 8'(i)}], idx: 8'(i), dummy: 1'b0});
        end
        drive(16'h4014, 1'b0, pg);
    endtask

    task automatic run_dma(input logic [7:0] pg, input bit want_align);
        int align;
        int stall;
        stall = 0;
        start_dma(pg, want_align, align);
        for (int c = 0; c < 600; c++) begin
            @(negedge clk); #1;
            if (cpu_rdy) break;
            stall++;
            drive_junk();
        end
        chk("stall_len", 32'(stall), 32'(513 + align));
        chk("queue_drained", 32'(q.size()), 32'd0);
        q.delete();
        drive(16'h0100, 1'b1, 8'h00);
    endtask

    initial begin
        int align;
        bit found;
        rst_n = 1'b0;
        drive(16'h1234, 1'b0, 8'h5A);
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0300 + i] = 8'(i) ^ 8'hA5;
        #1;
        chk("reset_rdy", 32'(cpu_rdy), 32'd1);
        chk("reset_active", 32'(dma_active), 32'd0);
        chk("reset_index", 32'(dma_index), 32'd0);
        chk("reset_mirror", {8'd0, bus_rw, bus_wdata, bus_addr}, {8'd0, 1'b0, 8'h5A, 16'h1234});
        drive(16'h0000, 1'b1, 8'h00);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        idle_ops(10);
        // Near-miss register accesses must not start a transfer.
        @(negedge clk); #1; drive(16'h4015, 1'b0, 8'h02);
        @(negedge clk); #1; drive(16'h4014, 1'b1, 8'h02);
        @(negedge clk); #1; drive(16'h4013, 1'b0, 8'h02);
        @(negedge clk); #1;
        chk("no_dma_rdy", 32'(cpu_rdy), 32'd1);
        idle_ops(5);

        run_dma(8'h02, 1'b0);
        idle_ops(4);
        run_dma(8'h02, 1'b1);
        idle_ops(4);
        run_dma(8'h03, 1'($urandom));
        idle_ops(4);
        run_dma(8'hFF, 1'($urandom));
        idle_ops(4);
        run_dma(8'h20, 1'($urandom));
        idle_ops(4);
        run_dma(8'($urandom), 1'($urandom));
        idle_ops(4);

        // Reset during the WRITE of byte 100.
        start_dma(8'h05, 1'($urandom), align);
        found = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk); #1;
            drive_junk();
            @(posedge clk); #1;
            if (dma_active && !bus_rw && dma_index == 8'd100) begin
                found = 1'b1;
                break;
            end
        end
        chk("reached_index_100", 32'(found), 32'd1);
        drive(16'h0200, 1'b1, 8'h33);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rdy", 32'(cpu_rdy), 32'd1);
        chk("rst_mid_active", 32'(dma_active), 32'd0);
        chk("rst_mid_mirror", {8'd0, bus_rw, bus_wdata, bus_addr}, {8'd0, 1'b1, 8'h33, 16'h0200});
        q.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        idle_ops(20);
        chk("post_reset_rdy", 32'(cpu_rdy), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/oam_dma.md
# oam_dma

Sprite-DMA controller and bus arbiter between the 6502 core and the system bus. A CPU write to $4014 with value P halts the core and copies the 256 bytes at $P00–$PFF to OAMDATA ($2004), one read/write pair per byte. When idle the block passes the core's bus signals through unchanged. It sits between the cpu instance and the address decoder at the top level.

## Interface

Parameters:
- DMA_REG, 16'h4014, CPU write address that triggers DMA
- OAM_DATA, 16'h2004, destination address of every DMA write

Ports:
- clk  in  1  system clock; all state updates on negedge clk, matching the cpu
- rst_n  in  1  asynchronous, active-low reset
- cpu_addr  in  16  core address
- cpu_rw  in  1  core direction, 1 = read, 0 = write
- cpu_wdata  in  8  core write data
- cpu_rdy  out  1  1 = core may advance; 0 = core halted
- bus_addr  out  16  arbitrated address
- bus_rw  out  1  arbitrated direction, 1 = read
- bus_wdata  out  8  arbitrated write data
- bus_rdata  in  8  read data returned from the decoder
- dma_active  out  1  1 while the controller owns the bus
- dma_index  out  8  current byte index (debug)

## Operation

- States: IDLE, HALT, ALIGN, READ, WRITE (dma_state_t).
- IDLE: bus_* = cpu_* combinationally; cpu_rdy = 1; dma_active = 0.
- Trigger: in IDLE, at a clock edge with cpu_rw = 0 and cpu_addr = DMA_REG: latch page ← cpu_wdata, index ← 0, go HALT. The triggering write itself is passed through to the bus.
- HALT (1 cycle): cpu_rdy = 0, dma_active = 1, bus_rw = 1, bus_addr = cpu_addr (dummy read). Exit: parity = 1 → ALIGN; parity = 0 → READ.
- ALIGN (1 cycle): same bus drive as HALT; → READ.
- READ: bus_addr = {page, index}, bus_rw = 1. At the ending edge: latch ← bus_rdata; → WRITE.
- WRITE: bus_addr = OAM_DATA, bus_rw = 0, bus_wdata = latch. At the ending edge: index = 255 → IDLE; otherwise index ← index+1, → READ.
- Parity: a free-running flop toggling on every edge, reset to 0, independent of state.
- In every non-IDLE state: cpu_rdy = 0, dma_active = 1, and the core's bus signals are ignored, including any further $4014 writes.
- The index is 8 bits and never wraps into the next page. Any page value is legal, including $20 (PPU registers) and $40.

## Timing

- Reset values: state IDLE, cpu_rdy 1, dma_active 0, page 0, index 0, latch 0, parity 0. bus_* mirror cpu_* immediately.
- Stall length: 1 (HALT) + ALIGN (0 or 1) + 512 = 513 or 514 cycles, counted from the edge that samples the trigger to the edge that returns to IDLE.
- READ-to-WRITE latency: bus_rdata is sampled at the end of the READ cycle and appears on bus_wdata throughout the following WRITE cycle.
- cpu_rdy rises combinationally on the edge that enters IDLE. The core resumes on the next cycle with its bus passed through.
- Reset mid-DMA: the transfer is abandoned immediately and asynchronously. State goes to IDLE, cpu_rdy to 1. Bytes already written stay written; the transfer does not restart.
- Trigger on the same edge as reset release: ignored, because reset dominates.

## Structure

- Add to the shared common.sv package: dma_state_t enum; constants OAM_DMA_ADDR = 16'h4014 and OAMDATA_ADDR = 16'h2004, used as the parameter defaults.
- One module, no sub-modules. The bus mux is a single combinational block keyed on state.
- The cpu needs an rdy input. The top level wires cpu_rdy to it.

## Test plan

- Reset, then core write $02 to $4014 at parity 0 → HALT, then READ $0200, WRITE $2004 … READ $02FF, WRITE $2004. cpu_rdy is low for exactly 513 cycles.
- Same trigger issued at parity 1 → one ALIGN cycle is inserted; cpu_rdy is low for 514 cycles; the first READ is at $0200.
- Memory at $0300+i preloaded with i^8'hA5, DMA page $03 → the 256 writes to $2004 carry 8'hA5, 8'hA4, … in index order; the scoreboard matches all bytes.
- Assert rst_n low during WRITE with index 100 → cpu_rdy = 1, dma_active = 0, bus mirrors the core in the same cycle; no further $2004 writes occur.
- Core writes $4015 and reads $4014 → no DMA starts; cpu_rdy stays 1; the bus mirrors the core exactly.
- Page $FF → the last READ is at $FFFF, followed by a WRITE to $2004, then IDLE; there is no access to $0000.
